// File: rtl/control_ventilacion_alarma_pkg.sv
// Shared definitions for the ventilation/alarm supervisor: state encoding and
// the clamped hysteresis exit-level helper.
package control_ventilacion_alarma_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      NORMAL     = 2'd0,
      VENTILANDO = 2'd1,
      ALARMA     = 2'd2
   } estado_t;

   // A threshold minus its hysteresis, floored at zero so small thresholds never wrap.
   function automatic int exit_level(input int thr, input int hist);
      return (hist > thr) ? 0 : thr - hist;
   endfunction

endpackage

// File: rtl/control_ventilacion_alarma_contador_persistencia.sv
// Persistence counter: tracks the candidate state and how many consecutive valid
// samples have pointed at it; pulses 'reach' on the sample that completes the run.
module control_ventilacion_alarma_contador_persistencia
   import control_ventilacion_alarma_pkg::*;
#(
   parameter int N_MUESTRAS = 4,
   parameter int CNT_W      = $clog2(N_MUESTRAS + 1)
) (
   input  logic    clk,
   input  logic    reset,
   input  estado_t target,
   input  estado_t state,
   input  logic    valid,
   input  logic    enable,
   output logic    reach,
   output estado_t cand
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N_MUESTRAS);

   estado_t          cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_new;

   always_comb begin
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      cnt_new = cnt_q;
      reach   = 1'b0;
      if (valid) begin
         if (target == state) begin
            cand_d = state;
            cnt_d  = '0;
         end else if (!enable) begin
            cnt_d = '0;
         end else begin
            if (target == cand_q) begin
               cnt_new = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
               cand_d  = target;
               cnt_new = CNT_W'(1);
            end
            // Completing the run hands the candidate to the FSM and restarts counting.
            if (cnt_new == CNT_N) begin
               reach = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_new;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cand_q <= NORMAL;
         cnt_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cand = cand_d;

endmodule

// File: rtl/control_ventilacion_alarma.sv
// Temperature supervisor driving Ventilacion/Alarma with hysteresis and N-sample
// persistence. Define ALARMA_ENCLAVADA_EN to latch ALARMA until Reconocer is seen.
module control_ventilacion_alarma
   import control_ventilacion_alarma_pkg::*;
#(
   parameter int TEMP_W     = 8,
   parameter int T_VENT     = 30,
   parameter int T_ALARMA   = 45,
   parameter int HIST       = 2,
   parameter int N_MUESTRAS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TEMP_W-1:0] Temperatura,
   input  logic              Dato_valido,
   input  logic              Reconocer,
   output logic              Ventilacion,
   output logic              Alarma,
   output logic [ST_W-1:0]   Estado
);

   localparam int                CNT_W = $clog2(N_MUESTRAS + 1);
   localparam logic [TEMP_W-1:0] TH_V  = TEMP_W'(T_VENT);
   localparam logic [TEMP_W-1:0] TH_A  = TEMP_W'(T_ALARMA);
   localparam logic [TEMP_W-1:0] LV    = TEMP_W'(exit_level(T_VENT, HIST));
   localparam logic [TEMP_W-1:0] LA    = TEMP_W'(exit_level(T_ALARMA, HIST));

   estado_t state_q, state_d, target, cand;
   logic    ventilacion_q, ventilacion_d, alarma_q, alarma_d;
   logic    reach, enable;

   always_comb begin
      target = NORMAL;
      case (state_q)
         NORMAL: begin
            if (Temperatura >= TH_A)      target = ALARMA;
            else if (Temperatura >= TH_V) target = VENTILANDO;
            else                          target = NORMAL;
         end
         VENTILANDO: begin
            if (Temperatura >= TH_A)    target = ALARMA;
            else if (Temperatura < LV)  target = NORMAL;
            else                        target = VENTILANDO;
         end
         ALARMA: begin
            if (Temperatura < LV)       target = NORMAL;
            else if (Temperatura < LA)  target = VENTILANDO;
            else                        target = ALARMA;
         end
         default: target = NORMAL;
      endcase
   end

   control_ventilacion_alarma_contador_persistencia #(
      .N_MUESTRAS (N_MUESTRAS),
      .CNT_W      (CNT_W)
   ) u_contador (
      .clk    (clk),
      .reset  (reset),
      .target (target),
      .state  (state_q),
      .valid  (Dato_valido),
      .enable (enable),
      .reach  (reach),
      .cand   (cand)
   );

   // Outputs are decoded from the next state so they move on the accepting edge.
   always_comb begin
      case (state_q)
         NORMAL, VENTILANDO, ALARMA: state_d = reach ? cand : state_q;
         default:                    state_d = NORMAL;
      endcase
      ventilacion_d = (state_d == VENTILANDO);
      alarma_d      = (state_d == ALARMA);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= NORMAL;
         ventilacion_q <= 1'b0;
         alarma_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ventilacion_q <= ventilacion_d;
         alarma_q      <= alarma_d;
      end
   end

`ifdef ALARMA_ENCLAVADA_EN
   logic ack_q, ack_d;

   // Entering ALARMA re-arms the latch; only an acknowledge inside ALARMA releases it.
   always_comb begin
      ack_d = ack_q;
      if (state_q == ALARMA && Reconocer) ack_d = 1'b1;
      if (state_d == ALARMA && state_q != ALARMA) ack_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) ack_q <= 1'b0;
      else       ack_q <= ack_d;
   end

   assign enable = (state_q != ALARMA) || ack_q;
`else
   logic unused_reconocer;
   assign unused_reconocer = Reconocer;
   assign enable           = 1'b1;
`endif

   assign Ventilacion = ventilacion_q;
   assign Alarma      = alarma_q;
   assign Estado      = state_q;

endmodule

// File: doc/control_ventilacion_alarma.md
Name: control_ventilacion_alarma

Overview:
Sequential temperature supervisor that produces the Ventilacion and Alarma signals consumed by the 7-segment activation display, i.e. the producing end of that interface. It samples a temperature word qualified by a valid strobe and applies thresholds with hysteresis and N-sample persistence. A three-state FSM drives mutually exclusive registered outputs, so the display decodes each state unambiguously.

Parameters:
TEMP_W, 8, width of the unsigned temperature sample
T_VENT, 30, ventilation entry threshold (inclusive)
T_ALARMA, 45, alarm entry threshold (inclusive); must be greater than T_VENT
HIST, 2, hysteresis subtracted from a threshold to get its exit level
N_MUESTRAS, 4, consecutive qualifying valid samples required to change state; must be at least 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Temperatura  input  TEMP_W  unsigned temperature sample
Dato_valido  input  1  Temperatura is sampled only on cycles where this is 1
Reconocer  input  1  alarm acknowledge pulse; used only when ALARMA_ENCLAVADA_EN is defined, ignored otherwise
Ventilacion  output  1  1 only in state VENTILANDO
Alarma  output  1  1 only in state ALARMA
Estado  output  2  current state encoding, for debug

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset (also mid-count): state=NORMAL, cand=NORMAL, cnt=0, Ventilacion=0, Alarma=0, Estado=0, ack flag=0.
- State encoding: NORMAL=0, VENTILANDO=1, ALARMA=2. Encoding 3 is illegal and recovers to NORMAL on the next clock.
- Exit levels: L_V = T_VENT-HIST and L_A = T_ALARMA-HIST, each clamped at 0 if HIST exceeds the threshold. Comparisons are unsigned at TEMP_W bits.
- Target for each valid sample, with T = Temperatura:
  - NORMAL: ALARMA if T>=T_ALARMA, else VENTILANDO if T>=T_VENT, else NORMAL.
  - VENTILANDO: ALARMA if T>=T_ALARMA, else NORMAL if T<L_V, else VENTILANDO.
  - ALARMA: NORMAL if T<L_V, else VENTILANDO if T<L_A, else ALARMA.
- Persistence rules, evaluated only on cycles with Dato_valido=1:
  - target==state: cnt=0, cand=state.
  - target!=state and target==cand: cnt=cnt+1, saturating.
  - target!=state and target!=cand: cand=target, cnt=1.
  - When the updated cnt equals N_MUESTRAS: state=cand and cnt=0 on that same edge.
- Cycles with Dato_valido=0 hold cnt, cand and state unchanged.
- Outputs are registered and decoded from the next-state value. They change on the edge that accepts the Nth qualifying sample, i.e. one cycle after that sample is presented.
- Ventilacion and Alarma are never 1 simultaneously.
- A direct NORMAL->ALARMA or ALARMA->NORMAL transition is legal.
- cnt width is clog2(N_MUESTRAS+1).

Optional Feature:
ALARMA_ENCLAVADA_EN
- Defined:
  - Ack flag is cleared on entry to ALARMA.
  - Reconocer=1 sets the flag while in ALARMA.
  - Persistence counting out of ALARMA is enabled only while the flag is 1; until then cnt is held at 0 in ALARMA.
  - Reconocer outside ALARMA has no effect.
- Undefined: Reconocer is ignored and ALARMA exits purely on the hysteresis and persistence rules.

Decomposition:
- Shared package: state encoding localparams (NORMAL, VENTILANDO, ALARMA), state width, and a function computing the clamped exit level.
- One natural sub-module: contador_persistencia. It holds cand/cnt, takes inputs target, state, valid and enable, and outputs a one-cycle pulse when the count is reached, together with cand.

Test Plan (default parameters; L_V=28, L_A=43):
1. Reset, then four valid samples of 25 -> state NORMAL; Ventilacion=0, Alarma=0 throughout.
2. Valid 31,31,31, then 3 idle cycles, then valid 31 -> Ventilacion=1 exactly one cycle after the 4th valid sample; Alarma=0.
3. From NORMAL: 31,31,29,31,31,31 -> the 29 clears cnt and no transition occurs; one more 31 -> VENTILANDO.
4. In VENTILANDO: four samples of 29 -> remains VENTILANDO (29>=L_V). Then four samples of 27 -> NORMAL, outputs 0.
5. From NORMAL: 50x4 -> Alarma=1, Ventilacion=0. Then 46,46,31,31,31,31 -> VENTILANDO after the 4th sample of 31, because cand restarts at the first 31. Assert reset mid-count -> all outputs 0 on the next cycle.
6. With ALARMA_ENCLAVADA_EN, in ALARMA: 20x6 with no Reconocer -> stays in ALARMA. Pulse Reconocer, then 20x4 -> NORMAL. Without the macro, 20x4 -> NORMAL directly.
